markov_chain_builder: RTL and testbench

//  Trains the first-order note Markov chains from decomposed song fragments. Sits directly

---
 rtl/markov_chain_builder.sv | 196 +++++++++++++++++++
 tb/tb_markov_chain_builder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/markov_chain_builder.sv
// ----------------------------------------------------------------------------
// MarkovChainBuilder
// Trains a first-order note Markov chain from song fragments. One fragment of
// FRAG_NOTES notes is accepted at a time. Each consecutive note pair
// (prev -> cur) updates the successor row of 'prev'. A row holds SLOTS
// {note, count} successor slots.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   clear_req   request a full table wipe (sampled only while idle)
//   frag_valid  a fragment is offered on frag_data
//   frag_ready  fragment will be taken this cycle (idle and no clear request)
//   frag_data   packed fragment, note i at [i*NOTE_W +: NOTE_W], note 0 earliest
//   busy        high while wiping or walking a fragment
//   done        one-cycle pulse after the last pair of a fragment
//   drop_cnt    saturating count of transitions lost to full rows
//   rd_addr     row to read back
//   rd_data     registered row contents, slot s at [s*SLOT_W +: SLOT_W] = {note, count}
// ----------------------------------------------------------------------------
module markov_chain_builder #(
    parameter int NOTE_W     = 8,
    parameter int FRAG_NOTES = 150,
    parameter int NUM_STATES = 156,
    parameter int SLOTS      = 16,
    parameter int CNT_W      = 9,
    parameter int DROP_W     = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear_req,
    input  logic                              frag_valid,
    output logic                              frag_ready,
    input  logic [FRAG_NOTES*NOTE_W-1:0]      frag_data,
    output logic                              busy,
    output logic                              done,
    output logic [DROP_W-1:0]                 drop_cnt,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic [SLOTS*(NOTE_W+CNT_W)-1:0]   rd_data
);

    localparam int SLOT_W = NOTE_W + CNT_W;
    localparam int ROW_W  = SLOTS * SLOT_W;
    localparam int FRAG_W = FRAG_NOTES * NOTE_W;
    localparam int IDX_W  = $clog2(FRAG_NOTES);

    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_STATES - 1);
    localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(NUM_STATES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAG_NOTES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [DROP_W-1:0] DROP_MAX  = '1;

    typedef enum logic [1:0] {CLEAR, IDLE, WALK, DONE} BuilderState;

    BuilderState state, stateNext;

    logic [ROW_W-1:0]  chainTable [NUM_STATES];
    logic [FRAG_W-1:0] fragShift;
    logic [IDX_W-1:0]  pairIdx;
    logic [ADDR_W-1:0] rowPtr;

    logic [NOTE_W-1:0] prevNote;
    logic [NOTE_W-1:0] curNote;
    logic              pairValid;
    logic [NOTE_W-1:0] rowIdx;
    logic [ROW_W-1:0]  rowVal;
    logic [ROW_W-1:0]  newRow;
    logic              matchFound;
    logic              freeFound;
    int                matchSlot;
    int                freeSlot;
    logic [NOTE_W-1:0] slotNote;
    logic [CNT_W-1:0]  slotCnt;
    logic              rowWrite;

    // The captured fragment is shifted down one note per walk cycle, so the
    // current pair always sits in the two lowest note positions.
    assign prevNote  = fragShift[NOTE_W-1:0];
    assign curNote   = fragShift[2*NOTE_W-1:NOTE_W];
    assign pairValid = (state == WALK) && (prevNote <= LAST_NOTE) && (curNote <= LAST_NOTE);
    assign rowIdx    = pairValid ? prevNote : '0;
    assign rowVal    = chainTable[rowIdx];

    assign frag_ready = (state == IDLE) && !clear_req;
    assign busy       = (state == CLEAR) || (state == WALK);
    assign done       = (state == DONE);

    // State register; reset always restarts with a full table wipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. A clear request while idle takes priority over an
    // offered fragment, which is simply not accepted that cycle.
    always_comb begin
        stateNext = state;
        case (state)
            CLEAR: if (rowPtr == LAST_ROW) stateNext = IDLE;
            IDLE: begin
                if (clear_req) begin
                    stateNext = CLEAR;
                end else if (frag_valid) begin
                    stateNext = WALK;
                end
            end
            WALK:    if (pairIdx == LAST_IDX) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = CLEAR;
        endcase
    end

    // Slot search on the row of the previous note. An existing successor
    // entry is preferred; otherwise the lowest empty slot (count zero) is
    // claimed. Empty is decided by count alone, the note field is ignored.
    always_comb begin
        matchFound = 1'b0;
        freeFound  = 1'b0;
        matchSlot  = 0;
        freeSlot   = 0;
        slotNote   = '0;
        slotCnt    = '0;
        newRow     = rowVal;
        for (int s = 0; s < SLOTS; s++) begin
            slotNote = rowVal[s*SLOT_W+CNT_W +: NOTE_W];
            slotCnt  = rowVal[s*SLOT_W +: CNT_W];
            if (!matchFound && (slotCnt != '0) && (slotNote == curNote)) begin
                matchFound = 1'b1;
                matchSlot  = s;
            end
            if (!freeFound && (slotCnt == '0)) begin
                freeFound = 1'b1;
                freeSlot  = s;
            end
        end
        if (matchFound) begin
            if (rowVal[matchSlot*SLOT_W +: CNT_W] != CNT_MAX) begin
                newRow[matchSlot*SLOT_W +: CNT_W] = rowVal[matchSlot*SLOT_W +: CNT_W] + 1'b1;
            end
        end else if (freeFound) begin
            newRow[freeSlot*SLOT_W +: SLOT_W] = {curNote, CNT_W'(1)};
        end
        rowWrite = pairValid && (matchFound || freeFound);
    end

    // Control datapath: wipe pointer, fragment capture/shift, pair index,
    // drop counter and the registered read port. A read of a row written in
    // the same cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rowPtr   <= '0;
            pairIdx  <= '0;
            drop_cnt <= '0;
            rd_data  <= '0;
        end else begin
            rd_data <= (rd_addr <= LAST_ROW) ? chainTable[rd_addr] : '0;
            case (state)
                CLEAR: begin
                    rowPtr   <= rowPtr + 1'b1;
                    drop_cnt <= '0;
                end
                IDLE: begin
                    rowPtr <= '0;
                    if (frag_valid && !clear_req) begin
                        fragShift <= frag_data;
                        pairIdx   <= IDX_W'(1);
                    end
                end
                WALK: begin
                    fragShift <= fragShift >> NOTE_W;
                    pairIdx   <= pairIdx + 1'b1;
                    if (pairValid && !matchFound && !freeFound && (drop_cnt != DROP_MAX)) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table storage is not reset; the CLEAR state wipes it one row per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                chainTable[rowPtr] <= '0;
            end else if (rowWrite) begin
                chainTable[rowIdx] <= newRow;
            end
        end
    end

endmodule

// File: tb/tb_markov_chain_builder.sv
// ----------------------------------------------------------------------------
// tb_markov_chain_builder
// Directed and randomized fragments are fed to markov_chain_builder and the
// read-back table, drop counter and handshake timing are compared with a
// behavioural successor-table model held in plain arrays.
// ----------------------------------------------------------------------------
module tb_markov_chain_builder;

    localparam int NOTE_W     = 8;
    localparam int FRAG_NOTES = 150;
    localparam int NUM_STATES = 156;
    localparam int SLOTS      = 16;
    localparam int CNT_W      = 9;
    localparam int DROP_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int SLOT_W     = NOTE_W + CNT_W;
    localparam int ROW_W      = SLOTS * SLOT_W;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;
    localparam int DROP_SAT   = (1 << DROP_W) - 1;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           clear_req;
    logic                           frag_valid;
    logic                           frag_ready;
    logic [FRAG_NOTES*NOTE_W-1:0]   frag_data;
    logic                           busy;
    logic                           done;
    logic [DROP_W-1:0]              drop_cnt;
    logic [ADDR_W-1:0]              rd_addr;
    logic [ROW_W-1:0]               rd_data;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    int mNote [NUM_STATES][SLOTS];
    int mCnt  [NUM_STATES][SLOTS];
    int mDrop;
    int fragNotes [FRAG_NOTES];

    always #5 clk = ~clk;

    markov_chain_builder #(
        .NOTE_W(NOTE_W), .FRAG_NOTES(FRAG_NOTES), .NUM_STATES(NUM_STATES),
        .SLOTS(SLOTS), .CNT_W(CNT_W), .DROP_W(DROP_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .frag_valid(frag_valid),
        .frag_ready(frag_ready), .frag_data(frag_data), .busy(busy), .done(done),
        .drop_cnt(drop_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [ROW_W-1:0] observed,
                               input logic [ROW_W-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: a table of successor lists per source note.
    function automatic void modelWipe();
        for (int r = 0; r < NUM_STATES; r++) begin
            for (int s = 0; s < SLOTS; s++) begin
                mNote[r][s] = 0;
                mCnt[r][s]  = 0;
            end
        end
        mDrop = 0;
    endfunction

    function automatic void modelPair(int p, int c);
        if (p >= NUM_STATES || c >= NUM_STATES) return;
        for (int s = 0; s < SLOTS; s++) begin
            if (mCnt[p][s] > 0 && mNote[p][s] == c) begin
                if (mCnt[p][s] < CNT_SAT) mCnt[p][s]++;
                return;
            end
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (mCnt[p][s] == 0) begin
                mNote[p][s] = c;
                mCnt[p][s]  = 1;
                return;
            end
        end
        if (mDrop < DROP_SAT) mDrop++;
    endfunction

    function automatic void modelFragment();
        for (int i = 1; i < FRAG_NOTES; i++) modelPair(fragNotes[i-1], fragNotes[i]);
    endfunction

    function automatic logic [ROW_W-1:0] modelRow(int r);
        logic [ROW_W-1:0] row;
        row = '0;
        for (int s = 0; s < SLOTS; s++) begin
            row[s*SLOT_W +: SLOT_W] = {NOTE_W'(mNote[r][s]), CNT_W'(mCnt[r][s])};
        end
        return row;
    endfunction

    function automatic logic [FRAG_NOTES*NOTE_W-1:0] packFragment();
        logic [FRAG_NOTES*NOTE_W-1:0] v;
        v = '0;
        for (int i = 0; i < FRAG_NOTES; i++) v[i*NOTE_W +: NOTE_W] = NOTE_W'(fragNotes[i]);
        return v;
    endfunction

    function automatic void randomFragment();
        for (int i = 0; i < FRAG_NOTES; i++) begin
            if ($urandom_range(0, 15) == 0) fragNotes[i] = int'($urandom_range(156, 255));
            else fragNotes[i] = int'($urandom_range(0, 19));
        end
    endfunction

    // Offers fragNotes, checks done latency and the return of frag_ready,
    // then applies the same fragment to the model.
    task automatic applyStimulus(input string tag);
        int waitCycles;
        int cycles;
        waitCycles = 0;
        while (!frag_ready && waitCycles < 1000) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({tag, " ready"}, ROW_W'(frag_ready), ROW_W'(1));
        frag_data  = packFragment();
        frag_valid = 1'b1;
        @(posedge clk);
        cycles = 0;
        while (cycles < 400) begin
            @(negedge clk);
            if (cycles == 0) frag_valid = 1'b0;
            cycles++;
            if (done) break;
        end
        checkOutput({tag, " done latency"}, ROW_W'(cycles), ROW_W'(150));
        @(negedge clk);
        checkOutput({tag, " ready after done"}, ROW_W'({done, frag_ready}), ROW_W'(2'b01));
        modelFragment();
    endtask

    task automatic readRow(input int addr, output logic [ROW_W-1:0] row);
        rd_addr = ADDR_W'(addr);
        @(posedge clk);
        @(negedge clk);
        row = rd_data;
    endtask

    task automatic compareTable(input string tag);
        logic [ROW_W-1:0] row;
        for (int r = 0; r < NUM_STATES; r++) begin
            readRow(r, row);
            checkOutput($sformatf("%s row%0d", tag, r), row, modelRow(r));
        end
        readRow(int'($urandom_range(156, 255)), row);
        checkOutput({tag, " out of range read"}, row, '0);
        checkOutput({tag, " drop_cnt"}, ROW_W'(drop_cnt), ROW_W'(mDrop));
    endtask

    // Counts cycles with busy high, starting at the current negedge.
    task automatic countBusy(output int n, output bit sawDone);
        n = 0;
        sawDone = 1'b0;
        while (busy && n < 1000) begin
            if (done) sawDone = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [ROW_W-1:0] row;
        int busyCycles;
        bit sawDone;

        rst_n      = 1'b0;
        clear_req  = 1'b0;
        frag_valid = 1'b0;
        frag_data  = '0;
        rd_addr    = '0;
        modelWipe();

        // Reset values, then the full wipe after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", ROW_W'(busy), ROW_W'(1));
        checkOutput("reset frag_ready", ROW_W'(frag_ready), ROW_W'(0));
        checkOutput("reset done", ROW_W'(done), ROW_W'(0));
        checkOutput("reset drop_cnt", ROW_W'(drop_cnt), ROW_W'(0));
        checkOutput("reset rd_data", rd_data, '0);
        rst_n = 1'b1;
        countBusy(busyCycles, sawDone);
        checkOutput("initial clear cycles", ROW_W'(busyCycles), ROW_W'(156));
        checkOutput("initial clear no done", ROW_W'(sawDone), ROW_W'(0));
        checkOutput("ready after clear", ROW_W'(frag_ready), ROW_W'(1));
        readRow(0, row);
        checkOutput("row0 after clear", row, '0);
        readRow(155, row);
        checkOutput("row155 after clear", row, '0);
        $display("[TB] initial clear finished");

        // Alternating 1,2
        for (int i = 0; i < FRAG_NOTES; i++) fragNotes[i] = (i % 2 == 0) ? 1 : 2;
        applyStimulus("alt12");
        readRow(1, row);
        checkOutput("row1 slot0", ROW_W'(row[SLOT_W-1:0]), ROW_W'({8'd2, 9'd75}));
        readRow(2, row);
        checkOutput("row2 slot0", ROW_W'(row[SLOT_W-1:0]), ROW_W'({8'd1, 9'd74}));
        compareTable("alt12");

        // Repeated note 4 with one invalid note in the middle
        for (int i = 0; i < FRAG_NOTES; i++) fragNotes[i] = 4;
        fragNotes[70] = 200;
        applyStimulus("note4");
        readRow(4, row);
        checkOutput("row4 slot0", ROW_W'(row[SLOT_W-1:0]), ROW_W'({8'd4, 9'd147}));

        // Seventeen distinct successors of note 3 overflow its row
        for (int i = 0; i < FRAG_NOTES; i++) fragNotes[i] = (i % 2 == 0) ? 3 : 10 + ((i / 2) % 17);
        applyStimulus("row full");
        readRow(3, row);
        for (int s = 0; s < SLOTS; s++) begin
            checkOutput($sformatf("row3 slot%0d note", s),
                        ROW_W'(row[s*SLOT_W+CNT_W +: NOTE_W]), ROW_W'(10 + s));
        end
        checkOutput("drop after row full", ROW_W'(drop_cnt), ROW_W'(4));
        compareTable("row full");

        // Count saturation on a self-transition
        for (int i = 0; i < FRAG_NOTES; i++) fragNotes[i] = 7;
        for (int k = 0; k < 4; k++) applyStimulus($sformatf("note7 #%0d", k));
        readRow(7, row);
        checkOutput("row7 saturated", ROW_W'(row[SLOT_W-1:0]), ROW_W'({8'd7, 9'd511}));

        // Random fragments over a small alphabet with occasional invalid notes
        for (int k = 0; k < 3; k++) begin
            randomFragment();
            applyStimulus($sformatf("random #%0d", k));
        end
        compareTable("random");

        // Clear request beats a same-cycle fragment
        randomFragment();
        @(negedge clk);
        clear_req  = 1'b1;
        frag_valid = 1'b1;
        frag_data  = packFragment();
        #1;
        checkOutput("ready with clear_req", ROW_W'(frag_ready), ROW_W'(0));
        @(posedge clk);
        @(negedge clk);
        clear_req  = 1'b0;
        frag_valid = 1'b0;
        countBusy(busyCycles, sawDone);
        checkOutput("clear_req cycles", ROW_W'(busyCycles), ROW_W'(156));
        checkOutput("clear_req no done", ROW_W'(sawDone), ROW_W'(0));
        modelWipe();
        compareTable("after clear_req");

        // Reset in the middle of a walk
        for (int i = 0; i < FRAG_NOTES; i++) fragNotes[i] = (i % 3) + 20;
        frag_data  = packFragment();
        frag_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frag_valid = 1'b0;
        sawDone = 1'b0;
        repeat (59) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("busy mid walk", ROW_W'(busy), ROW_W'(1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        countBusy(busyCycles, sawDone);
        checkOutput("reset mid walk clear cycles", ROW_W'(busyCycles), ROW_W'(156));
        checkOutput("reset mid walk no done", ROW_W'(sawDone), ROW_W'(0));
        checkOutput("ready after mid walk reset", ROW_W'(frag_ready), ROW_W'(1));
        modelWipe();
        compareTable("after mid walk reset");

        // Normal operation resumes
        randomFragment();
        applyStimulus("post reset");
        compareTable("post reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
